// File: rtl/apb_ram_if.sv
// APB bus bundle between the core's initiator port and the RAM responder.
// Pure wiring: the master drives address/control/write data, the slave returns read data, ready and error.
interface apb_ram_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pdata;
    logic [31:0]           prdata;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [3:0]            pstb;
    logic                  pready;
    logic                  perr;

    modport master (
        output paddr, pdata, psel, penable, pwrite, pstb,
        input  prdata, pready, perr
    );

    modport slave (
        input  paddr, pdata, psel, penable, pwrite, pstb,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_ram.sv
// APB responder over a word RAM with byte strobes, write-protected low words and error response.
// Latency: setup + WAIT_STATES+1 access cycles; pready is the only stall and lasts exactly one cycle.
module apb_ram #(
    parameter int                         APB_paddr_WIDTH = 32,
    parameter int                         DATA_WIDTH      = 32,
    parameter int                         DEPTH_WORDS     = 1024,
    parameter logic [APB_paddr_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                         RO_WORDS        = 0,
    parameter int                         WAIT_STATES     = 0,
    parameter string                      INIT_FILE       = ""
) (
    input  logic      clk,
    input  logic      rts_n,
    apb_ram_if.slave  apb
);
    localparam int AW     = APB_paddr_WIDTH;
    localparam int WOFF_W = AW - 2;
    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LANES  = DATA_WIDTH / 8;

    typedef enum logic {IDLE, ACCESS} state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  wr_q, wr_d;
    logic [3:0]            stb_q, stb_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic                  pready_q, pready_d;
    logic                  perr_q, perr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  mem_we;

    logic [AW-1:0]         offset;
    logic [WOFF_W-1:0]     word_off;
    logic                  in_range;
    logic                  dec_err;
    logic [IDX_W-1:0]      dec_idx;
    logic                  unused_lsb;

    logic                  rsp;
    logic [IDX_W-1:0]      rsp_idx;
    logic                  rsp_err;
    logic                  rsp_wr;

    // Offset wraps modulo 2^AW; the explicit >= BASE_ADDR test rejects addresses below the window.
    always_comb begin
        offset   = apb.paddr - BASE_ADDR;
        word_off = offset[AW-1:2];
        in_range = (apb.paddr >= BASE_ADDR) && (word_off < WOFF_W'(DEPTH_WORDS));
        dec_idx  = word_off[IDX_W-1:0];
        dec_err  = !in_range || (apb.pwrite && (word_off < WOFF_W'(RO_WORDS)));
    end

    assign unused_lsb = ^offset[1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        err_d    = err_q;
        wr_d     = wr_q;
        stb_d    = stb_q;
        wdat_d   = wdat_q;
        pready_d = pready_q;
        perr_d   = perr_q;
        prdata_d = prdata_q;
        mem_we   = 1'b0;
        rsp      = 1'b0;
        rsp_idx  = idx_q;
        rsp_err  = err_q;
        rsp_wr   = wr_q;

        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    idx_d   = dec_idx;
                    err_d   = dec_err;
                    wr_d    = apb.pwrite;
                    stb_d   = apb.pstb;
                    wdat_d  = apb.pdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ACCESS;
                    if (WAIT_STATES == 0) begin
                        rsp     = 1'b1;
                        rsp_idx = dec_idx;
                        rsp_err = dec_err;
                        rsp_wr  = apb.pwrite;
                    end
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    state_d  = IDLE;
                    pready_d = 1'b0;
                    perr_d   = 1'b0;
                    prdata_d = '0;
                end else if (!pready_q) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) rsp = 1'b1;
                end else if (apb.penable) begin
                    mem_we   = wr_q && !err_q;
                    state_d  = IDLE;
                    pready_d = 1'b0;
                    perr_d   = 1'b0;
                    prdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rsp) begin
            pready_d = 1'b1;
            perr_d   = rsp_err;
            prdata_d = (!rsp_err && !rsp_wr) ? mem_q[rsp_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rts_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            stb_q    <= '0;
            wdat_q   <= '0;
            pready_q <= 1'b0;
            perr_q   <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
            stb_q    <= stb_d;
            wdat_q   <= wdat_d;
            pready_q <= pready_d;
            perr_q   <= perr_d;
            prdata_q <= prdata_d;
        end
    end

    // Contents survive reset; a reset landing on the completion edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rts_n && mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (stb_q[i]) mem_q[idx_q][8*i +: 8] <= wdat_q[8*i +: 8];
            end
        end
    end

    assign apb.pready = pready_q;
    assign apb.perr   = perr_q;
    assign apb.prdata = prdata_q;
endmodule
